// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit for the single-cycle NPC core. Holds the
// architectural PC and fetches one 32-bit instruction at a time over a
// request/response handshake. The fetched word is presented to
// decode/execute until it is retired. On retirement the PC advances to
// pc+4 or to the ALU target. Fetching stops on an ebreak halt or on a
// fetch fault, which is either a bus error or a misaligned next PC.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_req_valid_o  -> imem_req_valid   fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     fetch address, always equal to pc
//   imem_resp_valid   response valid
//   imem_resp_data    fetched instruction word
//   imem_resp_err     bus error, qualified by imem_resp_valid
//   inst, pc          instruction and its PC, sent to the decoder
//   inst_valid        inst/pc are valid for execution
//   inst_ready        execute retires the instruction this cycle
//   pc_src            0: pc+4, 1: alu_target with bit 0 cleared
//   alu_target        jump target from the ALU
//   halt              ebreak detected on the current inst
//   halted            terminal halt state
//   fetch_fault       terminal fault state
//   inst_count        number of retired instructions, wraps around
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [31:0]      imem_req_addr,
   input  logic             imem_resp_valid,
   input  logic [31:0]      imem_resp_data,
   input  logic             imem_resp_err,
   output logic [31:0]      inst,
   output logic [31:0]      pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   input  logic             pc_src,
   input  logic [31:0]      alu_target,
   input  logic             halt,
   output logic             halted,
   output logic             fetch_fault,
   output logic [CNT_W-1:0] inst_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_valid_q, inst_valid_q, halted_q, fault_q;
   logic [31:0]      npc;

   // Jump targets drop bit 0. Bit 1 is then the only misalignment left.
   assign npc = pc_src ? (alu_target & ~32'd1) : pc_q + 32'd4;

   // NOTE: every signal gets a default before the case statement. A path
   // that leaves a combinational output unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A response arriving in any other state is a stray and is dropped.
            if (imem_resp_valid) begin
               if (imem_resp_err) begin
                  state_d = S_FAULT;
               end else begin
                  inst_d  = imem_resp_data;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (halt) begin
                  state_d = S_HALT;
               end else if (npc[1]) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d    = npc;
                  state_d = S_REQ;
               end
            end
         end
         S_HALT, S_FAULT: state_d = state_q;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state. This way they stay exact
   // decodes of state_q without a combinational path to the ports.
   // NOTE: sequential state uses non-blocking assignments only. All flops
   // then sample the pre-edge values, whatever order they are written in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= NOP;
         cnt_q        <= '0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         cnt_q        <= cnt_d;
         req_valid_q  <= (state_d == S_REQ);
         inst_valid_q <= (state_d == S_HOLD);
         halted_q     <= (state_d == S_HALT);
         fault_q      <= (state_d == S_FAULT);
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign inst           = inst_q;
   assign pc             = pc_q;
   assign inst_valid     = inst_valid_q;
   assign halted         = halted_q;
   assign fetch_fault    = fault_q;
   assign inst_count     = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch: self-checking bench for ifu_fetch. Inputs are driven and
// outputs are sampled on the falling clock edge. Fetched words are pushed
// into a scoreboard when the memory responds. They are popped and compared
// when inst_valid rises.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        pc_src;
   logic [31:0] alu_target;
   logic        halt;
   logic        halted;
   logic        fetch_fault;
   logic [31:0] inst_count;

   ifu_fetch #(.RESET_PC(32'h8000_0000), .CNT_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .inst            (inst),
      .pc              (pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .pc_src          (pc_src),
      .alu_target      (alu_target),
      .halt            (halt),
      .halted          (halted),
      .fetch_fault     (fetch_fault),
      .inst_count      (inst_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sb_q[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_cnt;
   logic [31:0] cur_pc;
   logic [31:0] cur_inst;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
      inst_ready      = 1'b0;
      pc_src          = 1'b0;
      alu_target      = 32'h0;
      halt            = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst      = 1'b0;
      exp_cnt  = 32'd0;
      cur_pc   = 32'h8000_0000;
      cur_inst = 32'h0000_0013;
   endtask

   // Single fetch: optional request stall (with a stray response pulse),
   // response delay, and an optional bus error.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                        input int stall, input int delay, input logic err,
                        input logic stray);
      int t = 0;
      while (!imem_req_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("req_seen", imem_req_valid, 1);
      check("req_addr", imem_req_addr, exp_addr);
      for (int i = 0; i < stall; i++) begin
         imem_req_ready  = 1'b0;
         imem_resp_valid = stray && (i == 0);
         imem_resp_data  = 32'hDEAD_BEEF;
         @(negedge clk);
         imem_resp_valid = 1'b0;
         check("stall_valid", imem_req_valid, 1);
         check("stall_addr", imem_req_addr, exp_addr);
         check("stall_no_inst", inst_valid, 0);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      check("req_drop", imem_req_valid, 0);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check("no_inst_early", inst_valid, 0);
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      imem_resp_err   = err;
      if (!err) sb_q.push_back('{pc: exp_addr, inst: data});
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      if (err) begin
         check("err_fault", fetch_fault, 1);
         check("err_inst_kept", inst, cur_inst);
         check("err_no_valid", inst_valid, 0);
      end else begin
         check("inst_valid", inst_valid, 1);
         if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
         end else begin
            exp_t e = sb_q.pop_front();
            check("inst", inst, e.inst);
            check("pc", pc, e.pc);
            cur_pc   = e.pc;
            cur_inst = e.inst;
         end
      end
   endtask

   // Retire after bp backpressure cycles. halt/pc_src are waved during
   // backpressure to show that they have no effect without inst_ready.
   task automatic retire(input logic src, input logic [31:0] tgt, input logic h, input int bp);
      for (int i = 0; i < bp; i++) begin
         inst_ready = 1'b0;
         pc_src     = 1'b1;
         halt       = 1'b1;
         alu_target = 32'h0000_0000;
         @(negedge clk);
         check("bp_valid", inst_valid, 1);
         check("bp_inst", inst, cur_inst);
         check("bp_pc", pc, cur_pc);
      end
      inst_ready = 1'b1;
      pc_src     = src;
      alu_target = tgt;
      halt       = h;
      @(negedge clk);
      inst_ready = 1'b0;
      pc_src     = 1'b0;
      halt       = 1'b0;
      exp_cnt    = exp_cnt + 32'd1;
      check("inst_count", inst_count, exp_cnt);
      check("retire_valid_drop", inst_valid, 0);
   endtask

   task automatic no_req_for(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (imem_req_valid) seen++;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      exp_cnt  = 32'd0;
      cur_pc   = 32'h8000_0000;
      cur_inst = 32'h0000_0013;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fetch_fault, 0);
      check("rst_pc", pc, 32'h8000_0000);
      check("rst_addr", imem_req_addr, 32'h8000_0000);
      check("rst_inst", inst, 32'h0000_0013);
      check("rst_count", inst_count, 0);

      // First fetch: the request appears exactly one cycle after release
      rst = 1'b0;
      check("idle_no_req", imem_req_valid, 0);
      @(negedge clk);
      check("cycle1_req", imem_req_valid, 1);
      fetch(32'h8000_0000, 32'h0000_0297, 0, 0, 1'b0, 1'b0);
      retire(1'b0, 32'h0, 1'b0, 0);

      // Sequential fetches
      fetch(32'h8000_0004, 32'h0040_0093, 0, 0, 1'b0, 1'b0);
      retire(1'b0, 32'h0, 1'b0, 0);
      fetch(32'h8000_0008, 32'h0080_0113, 0, 0, 1'b0, 1'b0);
      retire(1'b0, 32'h0, 1'b0, 0);
      check("seq_count3", inst_count, 3);

      // Backpressure, then a jump whose odd target has bit 0 cleared
      fetch(32'h8000_000C, 32'h0F40_006F, 0, 0, 1'b0, 1'b0);
      retire(1'b1, 32'h8000_0101, 1'b0, 5);

      // Memory stalls with a stray response, then a misaligned jump
      fetch(32'h8000_0100, 32'h0000_8067, 4, 3, 1'b0, 1'b1);
      retire(1'b1, 32'h8000_0102, 1'b0, 0);
      check("misalign_fault", fetch_fault, 1);
      check("misalign_pc", pc, 32'h8000_0100);
      no_req_for("fault_no_req", 10);

      // Halt
      do_reset();
      fetch(32'h8000_0000, 32'h0010_0073, 0, 0, 1'b0, 1'b0);
      retire(1'b0, 32'h0, 1'b1, 0);
      check("halted", halted, 1);
      check("halt_pc", pc, 32'h8000_0000);
      no_req_for("halt_no_req", 20);
      check("halt_still", halted, 1);

      // Async reset mid-S_WAIT
      do_reset();
      fetch(32'h8000_0000, 32'h0000_0513, 0, 0, 1'b0, 1'b0);
      retire(1'b0, 32'h0, 1'b0, 0);
      begin
         int t = 0;
         while (!imem_req_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      check("pre_rst_addr", imem_req_addr, 32'h8000_0004);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      check("pre_rst_wait", imem_req_valid, 0);
      check("pre_rst_count", inst_count, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_req_valid", imem_req_valid, 0);
      check("arst_inst_valid", inst_valid, 0);
      check("arst_pc", pc, 32'h8000_0000);
      check("arst_inst", inst, 32'h0000_0013);
      check("arst_count", inst_count, 0);
      @(negedge clk);
      rst      = 1'b0;
      exp_cnt  = 32'd0;
      cur_pc   = 32'h8000_0000;
      cur_inst = 32'h0000_0013;

      // Restart, then a bus error
      fetch(32'h8000_0000, 32'h1234_5678, 0, 1, 1'b1, 1'b0);
      no_req_for("err_no_req", 5);
      check("err_count", inst_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit placed directly upstream of the control decoder in the single-cycle NPC core.
- Holds the architectural PC and fetches one 32-bit instruction at a time from instruction memory over a request/response handshake.
- Presents the instruction to decode/execute and, on retirement, advances the PC to either the sequential next PC or the ALU-computed target.
- Stops fetching on an ebreak halt or a fetch fault.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  32  fetch address, equal to pc
- imem_resp_valid  in  1  response data valid
- imem_resp_data  in  32  fetched instruction word
- imem_resp_err  in  1  bus error; qualified by imem_resp_valid
- inst  out  32  instruction to the decoder; registered
- pc  out  32  PC of inst
- inst_valid  out  1  inst/pc valid for execution
- inst_ready  in  1  execute retires the instruction this cycle
- pc_src  in  1  0 selects pc+4, 1 selects alu_target (the decoder's PCSrc)
- alu_target  in  32  jump target from the ALU
- halt  in  1  ebreak detected on the current inst
- halted  out  1  high in S_HALT
- fetch_fault  out  1  high in S_FAULT
- inst_count  out  CNT_W  number of retired instructions

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (applied asynchronously while rst=1):
  - state=S_IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_count=0.
  - All of imem_req_valid, inst_valid, halted and fetch_fault are 0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT, S_FAULT. Outputs are decoded from state only:
  - imem_req_valid = (state==S_REQ)
  - inst_valid = (state==S_HOLD)
  - halted = (state==S_HALT)
  - fetch_fault = (state==S_FAULT)
- imem_req_addr = pc at all times.
- Transitions:
  - S_IDLE -> S_REQ: unconditionally on the first edge after rst deasserts.
  - S_REQ -> S_WAIT: when imem_req_ready=1. Otherwise stay; addr is held stable while valid is high.
  - S_WAIT -> S_HOLD: on imem_resp_valid=1 && imem_resp_err=0. inst captures imem_resp_data.
  - S_WAIT -> S_FAULT: on imem_resp_valid=1 && imem_resp_err=1. inst is unchanged.
  - S_HOLD: stays while inst_ready=0; inst and pc are held stable.
  - S_HOLD, inst_ready=1 (retire): inst_count += 1 (wraps modulo 2^CNT_W). Then:
    - halt=1 -> S_HALT, pc unchanged.
    - else compute npc = pc_src ? {alu_target[31:1],1'b0} : pc+32'd4 (carry discarded; 32'hFFFF_FFFC+4 -> 0).
    - npc[1]==1 -> S_FAULT, pc unchanged.
    - else pc <= npc, -> S_REQ.
  - halt or pc_src while inst_ready=0: no effect.
  - S_HALT and S_FAULT are terminal until rst.
- Stray responses: imem_resp_valid outside S_WAIT is ignored. The memory model shares rst, so no request survives reset.
- Latency:
  - Request accepted same cycle as valid when ready=1.
  - inst_valid asserts the cycle after resp_valid.
  - With ready, resp and inst_ready all immediate: 3 cycles per instruction (REQ, WAIT, HOLD).
  - First request issues 1 cycle after reset release.
- Reset mid-operation: rst in any state returns all state to reset values immediately. A pending handshake is abandoned.

Test Plan:
- Reset/first fetch: release rst, ready=1, resp next cycle with data 32'h00000297.
  - -> req_valid=1 at cycle 1 with addr 32'h80000000.
  - -> inst_valid=1 at cycle 3 with inst=32'h00000297, pc=32'h80000000.
- Sequential: retire 3 instructions with pc_src=0 -> addrs 0x80000000, 0x80000004, 0x80000008; inst_count=3.
- Jump and backpressure:
  - Hold inst_ready=0 for 5 cycles -> inst/pc stable.
  - Then retire with pc_src=1, alu_target=32'h80000101 -> next addr 32'h80000100.
  - Next, alu_target=32'h80000102 -> fetch_fault=1, no further requests.
- Memory stalls: imem_req_ready low 4 cycles, then resp delayed 3 cycles -> addr held, single request, inst captured only on resp_valid. A resp_valid pulse in S_REQ is ignored.
- Halt: retire inst 32'h00100073 with halt=1 -> halted=1, inst_count incremented, imem_req_valid stays 0 for 20 cycles.
- Async reset: assert rst mid-S_WAIT between clock edges -> outputs zero immediately and pc=32'h80000000. Fetch restarts after release. A bus error response -> fetch_fault=1.
